// File: rtl/key_cmd_scheduler.sv
// PS/2 scan-code to game-command scheduler: parser FSM, held-key tracking and a 4-deep command FIFO.
// Optional auto-repeat of the active direction is built when KEY_REPEAT_EN is defined.
module key_cmd_scheduler #(
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] kb_data,
   input  logic       kb_ready,
   input  logic       kb_overflow,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [2:0] cmd,
   output logic [4:0] held,
   output logic [7:0] drop_cnt
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_EXT     = 2'd1;
   localparam logic [1:0] ST_BRK     = 2'd2;
   localparam logic [1:0] ST_EXT_BRK = 2'd3;

   // {valid, command index}; restart has no extended form
   function automatic logic [3:0] map_key(input logic [7:0] code, input logic ext);
      case (code)
         8'h75:   map_key = 4'b1000;
         8'h72:   map_key = 4'b1001;
         8'h6B:   map_key = 4'b1010;
         8'h74:   map_key = 4'b1011;
         8'h2D:   map_key = ext ? 4'b0000 : 4'b1100;
         default: map_key = 4'b0000;
      endcase
   endfunction

   // {valid, direction} of the highest-priority held direction
   function automatic logic [2:0] prio_dir(input logic [3:0] dirs);
      if (dirs[0]) begin
         prio_dir = 3'b100;
      end else if (dirs[1]) begin
         prio_dir = 3'b101;
      end else if (dirs[2]) begin
         prio_dir = 3'b110;
      end else if (dirs[3]) begin
         prio_dir = 3'b111;
      end else begin
         prio_dir = 3'b000;
      end
   endfunction

   logic [1:0] state_r, state_nxt_s;
   logic       kb_ev_s, ev_make_s, ev_brk_s, ev_ext_s;
   logic [3:0] key_s;
   logic [2:0] key_idx_s, pick_s;
   logic [4:0] key_bit_s;
   logic       make_new_s, brk_key_s;
   logic [4:0] held_r, held_nxt_s;
   logic [1:0] act_r, act_nxt_s;
   logic       act_vld_r, act_vld_nxt_s;
   logic       rep_push_s, push_s, do_push_s, pop_s, drop_s;
   logic [2:0] push_cmd_s;
   logic [2:0] mem_r [4];
   logic [1:0] wr_ptr_r, rd_ptr_r;
   logic [2:0] count_r;
   logic [7:0] drop_r;

   // Scan-code parser: next state and make/break event decode
   always_comb begin
      kb_ev_s     = kb_ready && !kb_overflow;
      state_nxt_s = state_r;
      ev_make_s   = 1'b0;
      ev_brk_s    = 1'b0;
      ev_ext_s    = 1'b0;
      if (kb_overflow) begin
         state_nxt_s = ST_IDLE;
      end else if (kb_ev_s) begin
         case (state_r)
            ST_IDLE: begin
               if (kb_data == 8'hE0) begin
                  state_nxt_s = ST_EXT;
               end else if (kb_data == 8'hF0) begin
                  state_nxt_s = ST_BRK;
               end else begin
                  ev_make_s = 1'b1;
               end
            end
            ST_EXT: begin
               if (kb_data == 8'hF0) begin
                  state_nxt_s = ST_EXT_BRK;
               end else if (kb_data == 8'hE0) begin
                  state_nxt_s = ST_EXT;
               end else begin
                  ev_make_s   = 1'b1;
                  ev_ext_s    = 1'b1;
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_BRK: begin
               ev_brk_s    = 1'b1;
               state_nxt_s = ST_IDLE;
            end
            ST_EXT_BRK: begin
               ev_brk_s    = 1'b1;
               ev_ext_s    = 1'b1;
               state_nxt_s = ST_IDLE;
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Held bitmap and active direction update
   always_comb begin
      key_s         = map_key(kb_data, ev_ext_s);
      key_idx_s     = key_s[2:0];
      key_bit_s     = 5'b00001 << key_idx_s;
      make_new_s    = ev_make_s && key_s[3] && ((held_r & key_bit_s) == 5'd0);
      brk_key_s     = ev_brk_s && key_s[3];
      pick_s        = prio_dir(held_r[3:0] & ~key_bit_s[3:0]);
      held_nxt_s    = held_r;
      act_nxt_s     = act_r;
      act_vld_nxt_s = act_vld_r;
      if (kb_overflow) begin
         held_nxt_s    = 5'd0;
         act_nxt_s     = 2'd0;
         act_vld_nxt_s = 1'b0;
      end else if (make_new_s) begin
         held_nxt_s = held_r | key_bit_s;
         if (!key_idx_s[2]) begin
            act_nxt_s     = key_idx_s[1:0];
            act_vld_nxt_s = 1'b1;
         end else begin
            act_nxt_s     = act_r;
            act_vld_nxt_s = act_vld_r;
         end
      end else if (brk_key_s) begin
         held_nxt_s = held_r & ~key_bit_s;
         if (act_vld_r && !key_idx_s[2] && (key_idx_s[1:0] == act_r)) begin
            act_nxt_s     = pick_s[1:0];
            act_vld_nxt_s = pick_s[2];
         end else begin
            act_nxt_s     = act_r;
            act_vld_nxt_s = act_vld_r;
         end
      end else begin
         held_nxt_s = held_r;
      end
   end

   // Parser state, held keys and active direction registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         held_r    <= 5'd0;
         act_r     <= 2'd0;
         act_vld_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         held_r    <= held_nxt_s;
         act_r     <= act_nxt_s;
         act_vld_r <= act_vld_nxt_s;
      end
   end

`ifdef KEY_REPEAT_EN
   logic [31:0] rep_cnt_r, rep_lim_s;
   logic        rep_first_r, rep_hit_s, act_chg_s;

   // Repeat timer terminal count; a same-cycle make or active change discards the repeat
   always_comb begin
      act_chg_s  = (act_vld_nxt_s != act_vld_r) || (act_vld_nxt_s && (act_nxt_s != act_r));
      rep_lim_s  = rep_first_r ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_RATE - 1);
      rep_hit_s  = act_vld_r && (rep_cnt_r == rep_lim_s);
      rep_push_s = rep_hit_s && !act_chg_s && !kb_overflow && !make_new_s;
   end

   // Repeat timer restarts its initial delay whenever the active direction changes
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt_r   <= 32'd0;
         rep_first_r <= 1'b1;
      end else if (!act_vld_nxt_s || act_chg_s) begin
         rep_cnt_r   <= 32'd0;
         rep_first_r <= 1'b1;
      end else if (rep_hit_s) begin
         rep_cnt_r   <= 32'd0;
         rep_first_r <= 1'b0;
      end else begin
         rep_cnt_r   <= rep_cnt_r + 32'd1;
      end
   end
`else
   assign rep_push_s = 1'b0;
`endif

   // Single push source per cycle and FIFO handshake
   always_comb begin
      push_s     = make_new_s || rep_push_s;
      push_cmd_s = make_new_s ? key_idx_s : {1'b0, act_r};
      pop_s      = (count_r != 3'd0) && cmd_ready;
      do_push_s  = push_s && ((count_r != 3'd4) || pop_s);
      drop_s     = push_s && (count_r == 3'd4) && !pop_s;
   end

   // Command FIFO storage, pointers, occupancy and saturating drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            mem_r[i] <= 3'd0;
         end
         wr_ptr_r <= 2'd0;
         rd_ptr_r <= 2'd0;
         count_r  <= 3'd0;
         drop_r   <= 8'd0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_cmd_s;
            wr_ptr_r        <= wr_ptr_r + 2'd1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 2'd1;
         end
         case ({do_push_s, pop_s})
            2'b10:   count_r <= count_r + 3'd1;
            2'b01:   count_r <= count_r - 3'd1;
            default: count_r <= count_r;
         endcase
         if (drop_s && (drop_r != 8'hFF)) begin
            drop_r <= drop_r + 8'd1;
         end
      end
   end

   assign cmd_valid = (count_r != 3'd0);
   assign cmd       = mem_r[rd_ptr_r];
   assign held      = held_r;
   assign drop_cnt  = drop_r;

endmodule

// File: doc/key_cmd_scheduler.md
KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 25000000, meaning clk cycles from key press to first auto-repeat.
REQ-002 SHALL have parameter REPEAT_RATE, default 5000000, meaning clk cycles between successive auto-repeats.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port kb_data  input  8  scan-code byte from the PS/2 receiver.
REQ-006 SHALL have port kb_ready  input  1  one-cycle strobe; kb_data valid when high.
REQ-007 SHALL have port kb_overflow  input  1  receiver overflow flag.
REQ-008 SHALL have port cmd_valid  output  1  command FIFO non-empty.
REQ-009 SHALL have port cmd_ready  input  1  consumer accepts head command.
REQ-010 SHALL have port cmd  output  3  head command: 0 up, 1 down, 2 left, 3 right, 4 restart.
REQ-011 SHALL have port held  output  5  held-key bitmap: bit0 up, bit1 down, bit2 left, bit3 right, bit4 restart.
REQ-012 SHALL have port drop_cnt  output  8  saturating count of commands dropped on full FIFO.

Function
REQ-013 Parser FSM states SHALL be IDLE, EXT, BRK, EXT_BRK, advancing only on kb_ready.
REQ-014 IDLE: E0->EXT; F0->BRK; other byte->make event, stay IDLE.
REQ-015 EXT: F0->EXT_BRK; E0->stay EXT; other->extended make, ->IDLE.
REQ-016 BRK: any byte->break event, ->IDLE. EXT_BRK: any byte->extended break, ->IDLE.
REQ-017 Key map: 75 up, 72 down, 6B left, 74 right, accepted with or without E0; 2D restart, non-extended only; all other codes ignored with no state change beyond the FSM.
REQ-018 Make of a key not held SHALL set its held bit and push its command, both visible the cycle after the kb_ready strobe; make of an already-held key SHALL be ignored.
REQ-019 Break SHALL clear the held bit and push nothing.
REQ-020 Active direction SHALL be the most recently pressed held direction; on its release, the active direction SHALL become the highest-priority remaining held direction (up>down>left>right), or none.
REQ-021 Restart SHALL never be active and SHALL never repeat.
REQ-022 FIFO: 4 entries; cmd_valid=non-empty; cmd=head; pop when cmd_valid&&cmd_ready.
REQ-023 A push to a full FIFO without a same-cycle pop SHALL be dropped and increment drop_cnt, which saturates at 255. A push and pop in the same cycle on a full FIFO SHALL both occur with no drop.
REQ-024 At most one push per cycle; a make event SHALL take precedence over a repeat push in the same cycle, and the repeat push SHALL be discarded.
REQ-025 kb_overflow high SHALL return the FSM to IDLE, clear held, set active to none, and stop the repeat timer; FIFO contents and drop_cnt SHALL be retained.

Reset
REQ-026 rst high at a clk edge SHALL put the FSM in IDLE, empty the FIFO, and zero the repeat counter; cmd_valid, cmd, held and drop_cnt SHALL read 0 the next cycle.
REQ-027 rst asserted mid-sequence (e.g. after E0) SHALL discard the partial sequence.

Configuration
REQ-028 Macro KEY_REPEAT_EN SHALL control auto-repeat.
REQ-029 With KEY_REPEAT_EN defined: while a direction is active, the block SHALL push the active command REPEAT_DELAY cycles after it became active, then every REPEAT_RATE cycles. A change of active direction SHALL restart the delay.
REQ-030 With KEY_REPEAT_EN undefined: no repeat logic; only make events push commands.

Verification
REQ-031 Send 75 -> next cycle cmd_valid=1, cmd=0, held=5'b00001; send F0 75 -> held=0, no new command.
REQ-032 Send E0 74, then E0 F0 74 -> exactly one command, cmd=3; held returns to 0.
REQ-033 KEY_REPEAT_EN, REPEAT_DELAY=10, REPEAT_RATE=4, cmd_ready=1; press 6B at cycle 0 -> cmd=2 pushed at cycles 1, 11, 15, 19; resending 6B adds nothing.
REQ-034 cmd_ready=0; six press/release pairs of 72 -> 4 entries queued, drop_cnt=2; then cmd_ready=1 -> four pops of cmd=1.
REQ-035 Press 75, press 6B, release 6B -> active reverts to up; with repeat enabled, the next repeat push is cmd=0.
REQ-036 Send F0, then pulse kb_overflow, then send 75 -> treated as make: held=1, cmd=0.
